// File: rtl/vga_frame_source_sched.sv
// vga_frame_source_sched: hands the VGA pixel path to one requesting source per frame,
// round-robin with a minimum hold time, and forwards its blanked pixels with delay-matched syncs.
module vga_frame_source_sched #(
    parameter int VIDEO_WIDTH = 3,
    parameter int NUM_SRC     = 4,
    parameter int HOLD_FRAMES = 2
) (
    input  logic                           i_Clk,
    input  logic                           i_Rst_L,
    input  logic                           i_HSync,
    input  logic                           i_VSync,
    input  logic [NUM_SRC-1:0]             i_Req,
    input  logic [NUM_SRC*VIDEO_WIDTH-1:0] i_Red_Video,
    input  logic [NUM_SRC*VIDEO_WIDTH-1:0] i_Grn_Video,
    input  logic [NUM_SRC*VIDEO_WIDTH-1:0] i_Blu_Video,
    output logic [NUM_SRC-1:0]             o_Grant,
    output logic                           o_Frame_Start,
    output logic                           o_HSync,
    output logic                           o_VSync,
    output logic [VIDEO_WIDTH-1:0]         o_Red_Video,
    output logic [VIDEO_WIDTH-1:0]         o_Grn_Video,
    output logic [VIDEO_WIDTH-1:0]         o_Blu_Video
);
    localparam int IW = $clog2(NUM_SRC);
    localparam int CW = $clog2(HOLD_FRAMES + 2);

    // {found, index} of the first requester at or after ptr, ascending with wrap
    function automatic logic [IW:0] rr_pick(input logic [NUM_SRC-1:0] req, input logic [IW-1:0] ptr);
        rr_pick = '0;
        for (int i = NUM_SRC - 1; i >= 0; i--) begin
            if (req[(int'(ptr) + i) % NUM_SRC]) rr_pick = {1'b1, IW'((int'(ptr) + i) % NUM_SRC)};
        end
    endfunction

    logic          r_own;
    logic          r_VSync_d;
    logic [IW-1:0] r_owner;
    logic [IW-1:0] r_ptr;
    logic [CW-1:0] r_cnt;
    logic [IW:0]   w_all;
    logic [IW:0]   w_oth;
    logic [IW:0]   w_sel;
    logic [CW-1:0] w_cmp;
    logic          w_keep;
    logic          w_boundary;
    logic          w_active;
    logic          w_owner_req;

    assign w_boundary  = i_VSync & ~r_VSync_d;
    assign w_active    = i_HSync & i_VSync & r_own;
    assign w_cmp       = r_cnt + CW'(1);
    assign w_owner_req = r_own & i_Req[r_owner];
    assign w_all       = rr_pick(i_Req, r_ptr);
    assign w_oth       = rr_pick(i_Req & ~(NUM_SRC'(1) << r_owner), r_ptr);
    // A still-requesting owner yields only once its hold is served and someone else waits
    assign w_keep      = w_owner_req & ~((w_cmp >= CW'(HOLD_FRAMES)) & w_oth[IW]);
    assign w_sel       = w_owner_req ? w_oth : w_all;

    always_ff @(posedge i_Clk or negedge i_Rst_L) begin
        if (!i_Rst_L) begin
            r_own         <= 1'b0;
            r_VSync_d     <= 1'b1;
            r_owner       <= '0;
            r_ptr         <= '0;
            r_cnt         <= '0;
            o_Grant       <= '0;
            o_Frame_Start <= 1'b0;
            o_HSync       <= 1'b0;
            o_VSync       <= 1'b0;
            o_Red_Video   <= '0;
            o_Grn_Video   <= '0;
            o_Blu_Video   <= '0;
        end else begin
            r_VSync_d     <= i_VSync;
            o_Frame_Start <= w_boundary;
            o_HSync       <= i_HSync;
            o_VSync       <= i_VSync;
            o_Red_Video   <= w_active ? i_Red_Video[r_owner*VIDEO_WIDTH +: VIDEO_WIDTH] : '0;
            o_Grn_Video   <= w_active ? i_Grn_Video[r_owner*VIDEO_WIDTH +: VIDEO_WIDTH] : '0;
            o_Blu_Video   <= w_active ? i_Blu_Video[r_owner*VIDEO_WIDTH +: VIDEO_WIDTH] : '0;
            if (w_boundary) begin
                if (w_keep) begin
                    r_cnt <= (w_cmp > CW'(HOLD_FRAMES)) ? CW'(HOLD_FRAMES) : w_cmp;
                end else if (w_sel[IW]) begin
                    r_own   <= 1'b1;
                    r_owner <= w_sel[IW-1:0];
                    r_ptr   <= IW'((int'(w_sel[IW-1:0]) + 1) % NUM_SRC);
                    r_cnt   <= '0;
                    o_Grant <= NUM_SRC'(1) << w_sel[IW-1:0];
                end else begin
                    r_own   <= 1'b0;
                    o_Grant <= '0;
                end
            end
        end
    end
endmodule

// File: doc/vga_frame_source_sched.md
# vga_frame_source_sched

Frame-synchronous scheduler that shares the single VGA output path among NUM_SRC video sources (game, test pattern, overlay, ...). It takes the raw sync pulses from the sync-pulse generator and grants one requester per frame using round-robin arbitration with a minimum hold time. It forwards the granted source's pixels, blanked outside the active area, with syncs delay-matched. Sits between the sources and the porch/sync stage that drives the VGA connector.

## Interface
- VIDEO_WIDTH, 3, bits per colour channel
- NUM_SRC, 4, number of requesting sources (2..8)
- HOLD_FRAMES, 2, minimum complete frames an owner keeps the grant while others wait (>=1)

- i_Clk  in  1  pixel clock (25 MHz for 640x480)
- i_Rst_L  in  1  reset; one clock, reset is asynchronous and active-low
- i_HSync  in  1  high while column is in the active region
- i_VSync  in  1  high while row is in the active region
- i_Req  in  NUM_SRC  per-source request level, bit k = source k
- i_Red_Video, i_Grn_Video, i_Blu_Video  in  NUM_SRC*VIDEO_WIDTH each  packed pixels, source k in bits [k*VIDEO_WIDTH +: VIDEO_WIDTH]
- o_Grant  out  NUM_SRC  one-hot current owner, all-zero when idle
- o_Frame_Start  out  1  one-cycle pulse on each frame boundary
- o_HSync, o_VSync  out  1  inputs delayed one cycle
- o_Red_Video, o_Grn_Video, o_Blu_Video  out  VIDEO_WIDTH  selected, blanked pixels

## Operation
- Frame boundary: i_VSync==1 and r_VSync_d==0 (r_VSync_d = i_VSync registered). All arbitration happens only on boundaries; grant never changes mid-frame.
- State IDLE (o_Grant==0), state OWN (one grant bit set). Registers: owner index, RR pointer, held-frame counter (saturates at HOLD_FRAMES).
- RR search: starting at pointer, ascending with wrap, first k with i_Req[k]==1. On new grant to k: pointer <= (k+1) mod NUM_SRC, counter <= 0.
- IDLE at boundary: any request -> OWN with RR winner; none -> stay IDLE.
- OWN at boundary, completed = counter+1:
  - owner request low -> RR search over all sources (owner's bit is low so it cannot win); no winner -> IDLE.
  - owner request high, completed >= HOLD_FRAMES, another request pending -> OWN with RR winner excluding the owner.
  - otherwise keep owner, counter <= min(completed, HOLD_FRAMES).
- Requests dropped/raised mid-frame have no effect until the next boundary; only the value at the boundary cycle counts.
- Pixel path: if i_HSync & i_VSync and state OWN, output owner's channel; else output 0 on all channels.

## Timing
- Reset values: o_Grant=0, state IDLE, pointer=0, counter=0, r_VSync_d=1 (so a frame already active at reset release is not a boundary), o_Frame_Start=0, o_HSync=0, o_VSync=0, all video outputs 0.
- Boundary seen at cycle n: o_Frame_Start=1 and new o_Grant valid in cycle n+1.
- Video latency 1 cycle: outputs at n+1 computed from inputs, active flags and o_Grant at cycle n. First pixel of a new frame (cycle n) therefore uses the previous grant; sources must output black on the first active pixel. This matches the 1-cycle o_HSync/o_VSync delay.
- Reset asserted mid-frame: all outputs go to reset values immediately (asynchronous); after release, first grant occurs at the next true rising edge of i_VSync.
- Simultaneous owner-drop and new request at a boundary: handled in one decision; grant moves directly, no idle frame.

## Test plan
- NUM_SRC=4, HOLD_FRAMES=2, i_Req=0001 held from reset -> o_Grant=0001 from cycle after first VSync rise, no change over 5 frames, output = source 0 pixels in active area, 0 in blanking.
- i_Req=1111 constant -> grant sequence 0001,0001,0010,0010,0100,0100,1000,1000,0001 per frame.
- Owner 0 drops request mid-frame 3 with i_Req[2]=1 -> o_Grant stays 0001 until boundary, then 0100; no change mid-frame.
- All requests drop -> o_Grant=0000 after boundary, video outputs 0 throughout next frame, o_HSync/o_VSync still toggle with 1-cycle delay.
- HOLD_FRAMES=3, owner 1, source 3 raises request after 1 frame -> switch occurs only at the boundary ending owner's 3rd frame.
- Reset pulse mid-active-line with i_VSync high -> outputs 0 immediately; after release no grant until next VSync rising edge; o_Frame_Start pulses exactly once per frame thereafter.
